pe_grid_feeder: RTL and testbench
=================================

Name: pe_grid_feeder

Overview:
- Sequencer on the driving end of the PE_Grid_12x14 injection interface.
- Fetches a K×K kernel and a K×K image from a shared single-port read buffer.
- Preloads weights row by row using tag_row/valid_y, then injects image rows using image_val_vec/valid_x_vec.
- After a fixed drain it captures psum_outs[0..K-1] and streams them out over a valid/ready port. It replaces bench-driven stimulus in system builds.

Parameters:
- DATA_W, 16, Q7.8 weight/image word width.
- PSUM_W, 32, partial-sum width.
- COLS, 14, grid column count (vector length).
- K, 6, active kernel/image dimension; K ≤ 12 and K ≤ COLS.
- ADDR_W, 7, buffer address width.
- KBASE, 0, kernel base address (row-major, K*K words).
- IBASE, 36, image base address (row-major, K*K words).
- DRAIN, 4, idle cycles after the last image row before capture.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  start one K×K job; sampled only in IDLE.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse when the job completes.
- mem_rd_en  out  1  buffer read strobe.
- mem_rd_addr  out  ADDR_W  buffer read address.
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- row_weight_vals  out  COLS×DATA_W  weight row to grid.
- tag_row  out  4  target grid row for the weight load.
- valid_y  out  1  weight-load strobe.
- image_val_vec  out  COLS×DATA_W  image row to grid.
- valid_x_vec  out  COLS×1  per-column image strobe.
- psum_outs  in  COLS×PSUM_W  grid results.
- res_valid  out  1  result beat valid.
- res_ready  in  1  result beat accept.
- res_data  out  PSUM_W  result beat: psum_outs[j].
- res_last  out  1  high on beat j = K-1.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; all row/column counters go to 0.
  - Every output is 0, including all vector elements of row_weight_vals, image_val_vec and valid_x_vec.
  - Reset asserted mid-job aborts it immediately; no done pulse is issued.
- States and transitions:
  - IDLE: start=1 → W_FETCH with r=0.
  - W_FETCH (K+1 cycles, counter c=0..K):
    - For c<K: mem_rd_en=1, mem_rd_addr=KBASE+r*K+c.
    - For c≥1: mem_rd_data is latched into stage[c-1].
    - After c=K → W_SETUP.
  - W_SETUP (1 cycle): row_weight_vals[0..K-1]=stage, elements ≥K are 0, tag_row=r, valid_y=0. → W_STROBE.
  - W_STROBE (1 cycle): valid_y=1, same data and tag. → W_GAP.
  - W_GAP (1 cycle): valid_y=0, data and tag held. If r<K-1: r++ and → W_FETCH. Otherwise r=0 and → I_FETCH.
  - I_FETCH: same as W_FETCH but mem_rd_addr=IBASE+r*K+c. → I_STROBE.
  - I_STROBE (1 cycle): image_val_vec[0..K-1]=stage, valid_x_vec[0..K-1]=1; columns ≥K have value 0 and valid 0. → I_GAP.
  - I_GAP (1 cycle): all valid_x_vec=0, values held. If r<K-1: r++ and → I_FETCH. Otherwise → DRAIN.
  - DRAIN: exactly DRAIN cycles. → CAPTURE.
  - CAPTURE (1 cycle): latch psum_outs[0..K-1] into a result buffer. → OUT with j=0.
  - OUT:
    - res_valid=1, res_data=buf[j], res_last=(j==K-1).
    - The beat advances only when res_valid && res_ready.
    - While stalled, res_data and res_last hold.
    - Accepting the beat with j=K-1 → DONE.
  - DONE (1 cycle): done=1, busy=0. → IDLE.
- Invariants:
  - valid_y and any valid_x_vec bit are never high in the same cycle.
  - Each strobe is exactly 1 cycle wide.
  - mem_rd_en is low outside the FETCH states.
- Latency: K=6, DRAIN=4, res_ready held high:
  - Weight phase: 6 rows × 10 cycles = 60.
  - Image phase: 6 rows × 9 cycles = 54.
  - Drain 4 + capture 1 + output 6.
  - done is high in cycle 126 after the start-sampling edge.
- Boundary conditions:
  - start while busy or in DONE: ignored.
  - start held high across DONE → IDLE: a new job begins on the first IDLE cycle.
  - res_ready low indefinitely: FSM stays in OUT with the grid strobes idle.
  - The result buffer is not overwritten until the next CAPTURE.
  - psum_outs is not sign-extended or modified; it passes through bit-exact.

Test Plan:
- Reset mid-W_STROBE (r=3):
  - Outputs go to 0 asynchronously, before the next edge.
  - After release, start runs a full job from r=0.
- Kernel words 0x0100+n (n=0..35), start pulse:
  - Exactly 6 valid_y pulses with tag_row=0..5.
  - Pulse r has row_weight_vals[c]=0x0100+6r+c and elements 6..13 equal to 0.
- Image words 0x0010+n:
  - 6 single-cycle valid_x_vec pulses with bits 0..5 set (vector 0x003F).
  - Pulse r has image_val_vec[c]=0x0010+6r+c.
  - valid_y is never high at the same time.
- Memory model with 1-cycle latency: the read address sequence is 0..35 then 36..71, each issued once, with mem_rd_en only in FETCH states.
- psum_outs[j]=0xA000_0000+j, res_ready toggling 1,0,0,1…:
  - Exactly 6 beats 0xA0000000..0xA0000005 in order.
  - res_last only on the 6th beat.
  - Data held while stalled; done one cycle after the last accept.
- start re-pulsed at cycles 10 and 50 of a job: ignored; done pulses exactly once, at cycle 126 with res_ready held high.

Source files
------------

// File: rtl/pe_grid_feeder.sv
`default_nettype none
// ============================================================================
// Module      : pe_grid_feeder
// Description : Fetches a KxK kernel and a KxK image from a shared read buffer,
//               drives the PE grid weight/image strobes, then streams the
//               captured partial sums out over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_grid_feeder #(
    parameter int DATA_W = 16,
    parameter int PSUM_W = 32,
    parameter int COLS   = 14,
    parameter int K      = 6,
    parameter int ADDR_W = 7,
    parameter int KBASE  = 0,
    parameter int IBASE  = 36,
    parameter int DRAIN  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic [COLS*DATA_W-1:0]   row_weight_vals,
    output logic [3:0]               tag_row,
    output logic                     valid_y,
    output logic [COLS*DATA_W-1:0]   image_val_vec,
    output logic [COLS-1:0]          valid_x_vec,
    input  logic [COLS*PSUM_W-1:0]   psum_outs,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [PSUM_W-1:0]        res_data,
    output logic                     res_last
);

    localparam int c_DRAIN_W    = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam int c_DRAIN_LAST = (DRAIN > 0) ? DRAIN - 1 : 0;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_W_FETCH  = 4'd1,
        S_W_SETUP  = 4'd2,
        S_W_STROBE = 4'd3,
        S_W_GAP    = 4'd4,
        S_I_FETCH  = 4'd5,
        S_I_STROBE = 4'd6,
        S_I_GAP    = 4'd7,
        S_DRAIN    = 4'd8,
        S_CAPTURE  = 4'd9,
        S_OUT      = 4'd10,
        S_DONE     = 4'd11
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [3:0]             r_row;
    logic [3:0]             r_col;
    logic [3:0]             r_beat;
    logic [c_DRAIN_W-1:0]   r_drain;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_stage [K];
    logic [PSUM_W-1:0]      r_res   [K];

    logic                   w_fetch;
    logic                   w_last_row;
    logic                   w_last_col;
    logic [PSUM_W-1:0]      w_res_data;

    assign w_fetch    = (r_state == S_W_FETCH) || (r_state == S_I_FETCH);
    assign w_last_row = (r_row == 4'(K - 1));
    assign w_last_col = (r_col == 4'(K));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next_state = S_W_FETCH;
            S_W_FETCH:  if (w_last_col) w_next_state = S_W_SETUP;
            S_W_SETUP:  w_next_state = S_W_STROBE;
            S_W_STROBE: w_next_state = S_W_GAP;
            S_W_GAP:    w_next_state = w_last_row ? S_I_FETCH : S_W_FETCH;
            S_I_FETCH:  if (w_last_col) w_next_state = S_I_STROBE;
            S_I_STROBE: w_next_state = S_I_GAP;
            S_I_GAP: begin
                if (!w_last_row)     w_next_state = S_I_FETCH;
                else if (DRAIN == 0) w_next_state = S_CAPTURE;
                else                 w_next_state = S_DRAIN;
            end
            S_DRAIN:    if (r_drain == c_DRAIN_W'(c_DRAIN_LAST)) w_next_state = S_CAPTURE;
            S_CAPTURE:  w_next_state = S_OUT;
            S_OUT:      if (res_ready && (r_beat == 4'(K - 1))) w_next_state = S_DONE;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters, staging row and result buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row   <= '0;
            r_col   <= '0;
            r_beat  <= '0;
            r_drain <= '0;
            r_addr  <= '0;
            for (int i = 0; i < K; i++) begin
                r_stage[i] <= '0;
                r_res[i]   <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_row  <= '0;
                    r_col  <= '0;
                    r_addr <= ADDR_W'(KBASE);
                end
                S_W_FETCH, S_I_FETCH: begin
                    // Read data returns one cycle after its strobe, so column c
                    // lands while the counter already points at c+1.
                    for (int i = 0; i < K; i++) begin
                        if (r_col == 4'(i + 1)) r_stage[i] <= mem_rd_data;
                    end
                    if (w_last_col) begin
                        r_col <= '0;
                    end else begin
                        r_col  <= r_col + 4'd1;
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                S_W_GAP: begin
                    if (w_last_row) begin
                        r_row  <= '0;
                        r_addr <= ADDR_W'(IBASE);
                    end else begin
                        r_row <= r_row + 4'd1;
                    end
                end
                S_I_GAP: begin
                    r_drain <= '0;
                    r_row   <= w_last_row ? 4'd0 : r_row + 4'd1;
                end
                S_DRAIN: r_drain <= r_drain + c_DRAIN_W'(1);
                S_CAPTURE: begin
                    r_beat <= '0;
                    for (int i = 0; i < K; i++) begin
                        r_res[i] <= psum_outs[i*PSUM_W +: PSUM_W];
                    end
                end
                S_OUT: begin
                    if (res_ready && (r_beat != 4'(K - 1))) r_beat <= r_beat + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_res_data = '0;
        for (int i = 0; i < K; i++) begin
            if (r_beat == 4'(i)) w_res_data = r_res[i];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs are decoded from state so reset clears them without an edge
    // ------------------------------------------------------------------------
    always_comb begin
        busy            = (r_state != S_IDLE) && (r_state != S_DONE);
        done            = (r_state == S_DONE);
        mem_rd_en       = w_fetch && (r_col < 4'(K));
        mem_rd_addr     = mem_rd_en ? r_addr : '0;
        row_weight_vals = '0;
        tag_row         = '0;
        valid_y         = (r_state == S_W_STROBE);
        image_val_vec   = '0;
        valid_x_vec     = '0;
        res_valid       = (r_state == S_OUT);
        res_data        = '0;
        res_last        = 1'b0;

        if ((r_state == S_W_SETUP) || (r_state == S_W_STROBE) || (r_state == S_W_GAP)) begin
            tag_row = r_row;
            for (int i = 0; i < K; i++) begin
                row_weight_vals[i*DATA_W +: DATA_W] = r_stage[i];
            end
        end

        if ((r_state == S_I_STROBE) || (r_state == S_I_GAP)) begin
            for (int i = 0; i < K; i++) begin
                image_val_vec[i*DATA_W +: DATA_W] = r_stage[i];
                valid_x_vec[i]                    = (r_state == S_I_STROBE);
            end
        end

        if (r_state == S_OUT) begin
            res_data = w_res_data;
            res_last = (r_beat == 4'(K - 1));
        end
    end

    generate
        if (K < COLS) begin : g_unused_psum
            logic w_unused_psum;
            assign w_unused_psum = ^psum_outs[COLS*PSUM_W-1:K*PSUM_W];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pe_grid_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_grid_feeder
// Description : Scoreboard bench for pe_grid_feeder with a 1-cycle read buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_grid_feeder;

    localparam int DW    = 16;
    localparam int PW    = 32;
    localparam int COLS  = 14;
    localparam int K     = 6;
    localparam int AW    = 7;
    localparam int KBASE = 0;
    localparam int IBASE = 36;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 busy, done, mem_rd_en, valid_y, res_valid, res_last;
    logic [AW-1:0]        mem_rd_addr;
    logic [DW-1:0]        mem_rd_data = '0;
    logic [COLS*DW-1:0]   row_weight_vals, image_val_vec;
    logic [3:0]           tag_row;
    logic [COLS-1:0]      valid_x_vec;
    logic [COLS*PW-1:0]   psum_outs = '0;
    logic                 res_ready = 1'b1;
    logic [PW-1:0]        res_data;

    pe_grid_feeder dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .row_weight_vals(row_weight_vals), .tag_row(tag_row), .valid_y(valid_y),
        .image_val_vec(image_val_vec), .valid_x_vec(valid_x_vec), .psum_outs(psum_outs),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [3:0] tag; logic [COLS*DW-1:0] vec; } wexp_t;
    typedef struct packed { logic [COLS-1:0] vld; logic [COLS*DW-1:0] vec; } iexp_t;
    typedef struct packed { logic [PW-1:0] data; logic last; } rexp_t;

    wexp_t         wq[$];
    iexp_t         iq[$];
    logic [AW-1:0] aq[$];
    rexp_t         rq[$];
    int            dq[$];

    logic [DW-1:0] mem [128];
    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;
    int  n_done = 0;
    logic tog_mode = 1'b0;
    logic prev_vy = 1'b0, prev_vx = 1'b0, stalled = 1'b0, done_next = 1'b0;
    logic [PW-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 16'hDEAD;

    // res_ready pattern 1,0,0,1 repeating when toggling
    always @(posedge clk) begin
        #1;
        res_ready = tog_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    task automatic push_job(input int done_at);
        wexp_t w;
        iexp_t im;
        rexp_t r;
        for (int row = 0; row < K; row++) begin
            w.tag = 4'(row);
            w.vec = '0;
            im.vld = 14'h003F;
            im.vec = '0;
            for (int c = 0; c < K; c++) begin
                w.vec[c*DW +: DW]  = mem[KBASE + row*K + c];
                im.vec[c*DW +: DW] = mem[IBASE + row*K + c];
            end
            wq.push_back(w);
            iq.push_back(im);
        end
        for (int n = 0; n < K*K; n++) aq.push_back(AW'(KBASE + n));
        for (int n = 0; n < K*K; n++) aq.push_back(AW'(IBASE + n));
        for (int j = 0; j < K; j++) begin
            r.data = psum_outs[j*PW +: PW];
            r.last = (j == K - 1);
            rq.push_back(r);
        end
        dq.push_back(done_at);
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_ctrl"}, {busy, done, mem_rd_en, mem_rd_addr, tag_row, valid_y,
                               valid_x_vec, res_valid, res_last}, '0);
        check({tag, "_wvec"}, row_weight_vals, '0);
        check({tag, "_ivec"}, image_val_vec, '0);
        check({tag, "_res"}, res_data, '0);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 400 && n_done < target; i++) @(negedge clk);
        if (n_done < target) fail_now("done_timeout");
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_sb_empty"}, wq.size() + iq.size() + aq.size() + rq.size() + dq.size(), 0);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        wexp_t e;
        if (valid_y) begin
            check("vy_width", prev_vy, 1'b0);
            check("vy_vx_excl", valid_x_vec, '0);
            if (wq.size() == 0) fail_now("wload_extra");
            else begin
                e = wq.pop_front();
                check("wload_tag", tag_row, e.tag);
                check("wload_vec", row_weight_vals, e.vec);
            end
        end
        prev_vy = valid_y;
    end

    always @(negedge clk) begin
        iexp_t e;
        if (valid_x_vec != '0) begin
            check("vx_width", prev_vx, 1'b0);
            check("vx_vy_excl", valid_y, 1'b0);
            if (iq.size() == 0) fail_now("iload_extra");
            else begin
                e = iq.pop_front();
                check("iload_vld", valid_x_vec, e.vld);
                check("iload_vec", image_val_vec, e.vec);
            end
        end
        prev_vx = (valid_x_vec != '0);
    end

    always @(negedge clk) begin
        if (mem_rd_en) begin
            check("rd_outside_fetch", {valid_y, valid_x_vec, res_valid}, '0);
            if (aq.size() == 0) fail_now("rd_extra");
            else check("rd_addr", mem_rd_addr, aq.pop_front());
        end
    end

    always @(negedge clk) begin
        rexp_t e;
        if (done_next) begin
            check("done_after_last", done, 1'b1);
            done_next = 1'b0;
        end
        if (res_valid) begin
            if (stalled) check("res_hold", {res_data, res_last}, {prev_data, prev_last});
            if (res_ready) begin
                if (rq.size() == 0) fail_now("res_extra");
                else begin
                    e = rq.pop_front();
                    check("res_data", res_data, e.data);
                    check("res_last", res_last, e.last);
                    if (e.last) done_next = 1'b1;
                end
            end
        end
        stalled   = res_valid && !res_ready;
        prev_data = res_data;
        prev_last = res_last;
    end

    always @(negedge clk) begin
        int exp_t;
        if (done) begin
            n_done++;
            if (dq.size() == 0) fail_now("done_extra");
            else begin
                exp_t = dq.pop_front();
                if (exp_t >= 0) check("done_cycle", cyc, exp_t);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int dn;
        for (int n = 0; n < 128; n++) mem[n] = 16'h0000;
        for (int n = 0; n < 36; n++) begin
            mem[KBASE + n] = 16'h0100 + 16'(n);
            mem[IBASE + n] = 16'h0010 + 16'(n);
        end
        for (int j = 0; j < COLS; j++) psum_outs[j*PW +: PW] = 32'hDEAD_0000 + 32'(j);
        for (int j = 0; j < K; j++) psum_outs[j*PW +: PW] = 32'hF0F0_0000 + 32'(j * 32'h1001);

        repeat (3) @(negedge clk);
        check_outs_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Job 1: start re-pulsed at cycles 10 and 50 must be ignored
        t0 = cyc;
        start = 1'b1;
        push_job(t0 + 126);
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1);
        repeat (3) @(negedge clk);
        check("idle_after_job1", busy, 1'b0);
        check_drained("job1");

        // Job 2: reset while W_STROBE is presenting row 3
        t0 = cyc;
        start = 1'b1;
        push_job(t0 + 126);
        @(negedge clk);
        start = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (valid_y && tag_row == 4'd3) seen = 1'b1;
            end
            if (!seen) fail_now("row3_strobe_timeout");
        end
        #1 rst = 1'b0;
        #1 check_outs_zero("async_rst");
        wq.delete(); iq.delete(); aq.delete(); rq.delete(); dq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("no_done_on_abort", n_done, 1);

        // Job 3: new data, toggling res_ready
        for (int n = 0; n < 36; n++) begin
            mem[KBASE + n] = 16'hC000 + 16'(n * 3);
            mem[IBASE + n] = 16'h0F00 - 16'(n);
        end
        for (int j = 0; j < K; j++) psum_outs[j*PW +: PW] = 32'hA000_0000 + 32'(j);
        tog_mode = 1'b1;
        t0 = cyc;
        start = 1'b1;
        push_job(-1);
        @(negedge clk);
        start = 1'b0;
        wait_done(2);
        @(negedge clk);
        tog_mode = 1'b0;
        repeat (2) @(negedge clk);
        check_drained("job3");

        // Jobs 4 and 5: start held high across DONE -> IDLE
        for (int j = 0; j < K; j++) psum_outs[j*PW +: PW] = 32'h7FFF_FFF0 + 32'(j);
        t0 = cyc;
        start = 1'b1;
        push_job(t0 + 126);
        push_job(t0 + 253);
        while (cyc < t0 + 128) @(negedge clk);
        check("restart_busy", busy, 1'b1);
        start = 1'b0;
        dn = 4;
        wait_done(dn);
        repeat (3) @(negedge clk);
        check_drained("job5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
